// File: rtl/booth_pp_accumulator_if.sv
// Handshake and data bundle for booth_pp_accumulator.
//   master : drives the Booth rows (arr0..3, cx1..4, sx1..4), in_valid, out_ready
//   slave  : the accumulator; drives in_ready, out_valid, product, busy
interface booth_pp_accumulator_if #(
  parameter int unsigned PP_W   = 11,
  parameter int unsigned PROD_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PP_W-1:0]   arr0, arr1, arr2, arr3;
  logic              cx1, cx2, cx3, cx4;
  logic              sx1, sx2, sx3, sx4;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport master (
    output in_valid, arr0, arr1, arr2, arr3, cx1, cx2, cx3, cx4, sx1, sx2, sx3, sx4, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, arr0, arr1, arr2, arr3, cx1, cx2, cx3, cx4, sx1, sx2, sx3, sx4, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Serial accumulator for the four radix-4 Booth partial-product rows of an 8x8 signed
// multiplier. A row set is captured on in_valid/in_ready, summed one row per cycle
// (two rows per cycle with BOOTH_ACC_DUAL_EN defined) into a PROD_W-bit accumulator,
// and the product is offered on out_valid/out_ready.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : booth_pp_accumulator_if.slave (rows, carries, sign flags, handshakes, busy)
// Optional feature macro: BOOTH_ACC_DUAL_EN (second adder, 2-cycle accumulation).
module booth_pp_accumulator #(
  parameter int unsigned PP_W   = 11,
  parameter int unsigned PROD_W = 16
) (
  input logic                   clk,
  input logic                   rst,
  booth_pp_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e            state_q;
  logic [PP_W-1:0]   arr_q [4];
  logic [3:0]        cx_q;
  logic [3:0]        sx_q;
  logic [1:0]        cnt_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] product_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [PROD_W-1:0] sum_d;
  logic              last_d;

  // Sign flags are kept for visibility only; the carries already encode negation.
  logic unused_sx;
  assign unused_sx = ^sx_q;

  // Row k weight: sign-extended row plus its negation carry, shifted by 2k.
  function automatic logic [PROD_W-1:0] row_contrib(input logic [PP_W-1:0] arr,
                                                    input logic            cx,
                                                    input logic [1:0]      k);
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W-PP_W){arr[PP_W-1]}}, arr} + {{(PROD_W-1){1'b0}}, cx};
    return ext << {k, 1'b0};
  endfunction

`ifdef BOOTH_ACC_DUAL_EN
  logic [1:0] k_lo, k_hi;
  always_comb begin
    k_lo   = {cnt_q[0], 1'b0};
    k_hi   = {cnt_q[0], 1'b1};
    sum_d  = acc_q + row_contrib(arr_q[k_lo], cx_q[k_lo], k_lo)
                   + row_contrib(arr_q[k_hi], cx_q[k_hi], k_hi);
    last_d = (cnt_q == 2'd1);
  end
`else
  always_comb begin
    sum_d  = acc_q + row_contrib(arr_q[cnt_q], cx_q[cnt_q], cnt_q);
    last_d = (cnt_q == 2'd3);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cx_q        <= '0;
      sx_q        <= '0;
      for (int i = 0; i < 4; i++) arr_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            arr_q[0] <= bus.arr0;
            arr_q[1] <= bus.arr1;
            arr_q[2] <= bus.arr2;
            arr_q[3] <= bus.arr3;
            cx_q     <= {bus.cx4, bus.cx3, bus.cx2, bus.cx1};
            sx_q     <= {bus.sx4, bus.sx3, bus.sx2, bus.sx1};
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StAcc;
          end
        end
        StAcc: begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + 2'd1;
          if (last_d) begin
            product_q   <= sum_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Low while rst is held so the reset cycle never advertises readiness.
  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
- Sequential reduction stage directly downstream of the radix-4 Booth partial-product generator of the 8x8 signed fixed-point multiplier.
- Captures the four 11-bit partial-product rows plus their negation carries in one handshake.
- Accumulates the rows serially into a 16-bit signed product and presents the product on a valid/ready output.
- Trades area (one 16-bit adder) for 4-cycle latency.

Parameters:
- PP_W, 11, width of each partial-product row.
- PROD_W, 16, product width; every sum is taken modulo 2^PROD_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  rows and carries on the inputs are valid.
- in_ready  out  1  block can accept a row set.
- arr0, arr1, arr2, arr3  in  PP_W each  Booth rows 0..3; two's complement, bit PP_W-1 is the sign.
- cx1, cx2, cx3, cx4  in  1 each  negation carry for rows 0..3; added at the row's LSB weight.
- sx1, sx2, sx3, sx4  in  1 each  row sign flags; captured but not used in the arithmetic.
- out_valid  out  1  product is valid.
- out_ready  in  1  consumer accepts the product.
- product  out  PROD_W  signed product.
- busy  out  1  high in ACC state.

Behaviour:
- Row contribution: row k = (sign-extend arrk to PROD_W + zero-extend cx(k+1)) << 2k, for k = 0..3. product = sum of all four rows, mod 2^16.
- Reset (rst=1 at a clock edge):
  - state=IDLE, acc=0, row counter=0, all captured registers=0.
  - in_ready=0 during the reset cycle; in_ready=1 from the first cycle after reset deasserts.
  - out_valid=0, product=0, busy=0.
  - Reset overrides everything, including an in-flight accumulation or a held product; that data is discarded.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register arr0..3, cx1..4 and sx1..4; clear acc and the counter; go to ACC.
  - With in_valid=0, stay in IDLE.
- State ACC:
  - in_ready=0, busy=1.
  - Each cycle, acc <= acc + contribution(row k), with k = counter, then counter increments.
  - After k=3 is added, go to DONE. ACC lasts exactly 4 cycles.
  - Input changes during ACC are ignored.
- State DONE:
  - out_valid=1, product=acc, held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE; out_valid=0 in the next cycle.
  - out_ready may be high before out_valid; the handshake completes in the first DONE cycle.
- Latency: acceptance at edge T; out_valid rises after edge T+4 (T+2 with the optional feature).
- Throughput: one product per 6 cycles minimum (4 ACC + 1 DONE + 1 IDLE). No back-to-back overlap; in_ready is low in DONE.
- product holds its last value outside DONE; it is meaningful only while out_valid=1.
- Overflow: no saturation, wrap modulo 2^16. For all 8x8 signed operands the true product fits in 16 bits.
- The row counter is 2 bits and never wraps during ACC; the DONE transition is taken at counter==3.

Optional Feature:
- Macro BOOTH_ACC_DUAL_EN.
- Defined:
  - Two rows are added per ACC cycle (rows 0+1, then rows 2+3) using a second adder.
  - ACC lasts 2 cycles; latency is 2; minimum throughput is one product per 4 cycles.
  - Results are bit-identical to the single-row mode.
- Undefined: one row per cycle, as specified above; only one adder is present.

Test Plan:
- Drive the rows from the upstream Booth generator with a=3, b=5; hold out_ready=1 -> product=0x000F, out_valid exactly 4 cycles after acceptance (2 with BOOTH_ACC_DUAL_EN).
- a=-128, b=-128 -> product=0x4000. a=-128, b=127 -> product=0xC080. a=127, b=-1 -> product=0xFF81.
- a=0, b=-77; then a=-1, b=-1 -> product=0x0000, then 0x0001. in_ready low from acceptance until the cycle after the output handshake.
- Hold out_ready=0 for 10 cycles in DONE while the inputs toggle -> product and out_valid remain stable, in_ready=0. Raise out_ready -> one handshake, then IDLE.
- Assert rst in the 2nd ACC cycle -> next cycle out_valid=0, busy=0, product=0. A new operand pair then yields the correct product with no residue from the aborted operation.
- Exhaustive sweep of a,b over -128..127 with random out_ready backpressure -> every product equals a*b mod 2^16, in order, with none dropped or duplicated.
